// File: rtl/ok_buffered_pipe_in.sv
// rtl/ok_buffered_pipe_in.sv - host-to-FPGA pipe endpoint with FWFT FIFO
//
// Receives 16-bit host write strobes addressed to ep_addr and queues them in a
// DEPTH-entry first-word-fall-through FIFO for user logic.
//
// Ports:
//   ti_clk, ti_reset : host interface clock / synchronous active-high reset
//   ok1              : host bus in (write strobe, address, data)
//   ok2              : endpoint return bus, wired-OR; zero when not addressed
//   ep_addr          : static endpoint address, 0x80..0x9F
//   ep_dataout       : head-of-FIFO word, 0 when empty
//   ep_valid         : FIFO non-empty
//   ep_read          : pop request (ignored when empty)
//   ep_count         : occupancy 0..DEPTH
//   ep_overflow      : sticky, set when a host word is dropped
//   ep_clr_ovf       : clears ep_overflow (a same-cycle set wins)
module ok_buffered_pipe_in #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          ti_clk,
  input  logic          ti_reset,
  input  logic [30:0]   ok1,
  output logic [16:0]   ok2,
  input  logic [7:0]    ep_addr,
  output logic [15:0]   ep_dataout,
  output logic          ep_valid,
  input  logic          ep_read,
  output logic [AW:0]   ep_count,
  output logic          ep_overflow,
  input  logic          ep_clr_ovf
);

  // Host bus field positions
  localparam int OK_TI_WRITE       = 28;
  localparam int OK_TI_ADDR_END    = 23;
  localparam int OK_TI_ADDR_START  = 16;
  localparam int OK_TI_DATAIN_END  = 15;
  localparam int OK_TI_DATAIN_START = 0;
  localparam int OK_READY          = 16;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic        ti_write;
  logic [7:0]  ti_addr;
  logic [15:0] ti_datain;

  assign ti_write  = ok1[OK_TI_WRITE];
  assign ti_addr   = ok1[OK_TI_ADDR_END:OK_TI_ADDR_START];
  assign ti_datain = ok1[OK_TI_DATAIN_END:OK_TI_DATAIN_START];

  // Clock/reset copies and spare bits on ok1 are carried separately as ports.
  logic unused_ok1;
  assign unused_ok1 = ^{ok1[30:29], ok1[27:24]};

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic addressed;
  logic push;
  logic pop;
  logic not_full;
  logic accept;

  assign addressed = (ti_addr == ep_addr);
  assign push      = ti_write & addressed;
  assign not_full  = (count < FULL_CNT);
  assign pop       = ep_read & ep_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept    = push & (not_full | pop);

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) begin
        overflow <= 1'b1;
      end else if (ep_clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge ti_clk) begin
    if (!ti_reset && accept) begin
      mem[wr_ptr] <= ti_datain;
    end
  end

  always_ff @(posedge ti_clk) begin
    assert ((ep_addr >= 8'h80) && (ep_addr <= 8'h9F) &&
            (DEPTH >= 2) && (DEPTH == (1 << AW)))
    else begin
      $error("ok_buffered_pipe_in: bad ep_addr or DEPTH/AW");
      $finish;
    end
  end

  assign ep_valid    = (count != '0);
  assign ep_dataout  = ep_valid ? mem[rd_ptr] : 16'h0000;
  assign ep_count    = count;
  assign ep_overflow = overflow;

  always_comb begin
    ok2           = '0;
    ok2[OK_READY] = addressed & not_full;
  end

endmodule
